memory_load_unit: RTL

Read-side companion to the memory write datapath. It accepts a load request, computes the effective address with the same address modes as the store path, and issues a read to the synchronous data memory. It waits a fixed memory latency, captures the returned word and writes it back to one destination register (Mary, Shelley, RA or Comp) under a ready handshake. It sits between the control unit and the register write ports, and owns the memory read port.

---
 rtl/memory_load_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/memory_load_unit.sv
// memory_load_unit: accepts one load request at a time, computes the effective
// address, issues a single-cycle read to a synchronous data memory, waits
// MEM_LATENCY cycles, captures the returned word and writes it back to one
// destination register under a wb_ready handshake.
//
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake (req_ready only in IDLE)
//   addr_sel, dst_sel         address mode and destination select
//   pc, sp, mary_data,
//   shelley_data, imm         address operands (imm is signed 8-bit)
//   mem_addr, mem_read        memory read port (registered)
//   mem_rdata                 memory read data
//   wb_data                   captured load data (registered)
//   mary_write, shelley_write,
//   ra_write, comp_write      one-hot writeback strobes (registered)
//   wb_ready                  register file accepts writeback this cycle
//   busy                      state != IDLE
//   err                       one-cycle pulse on a rejected request
//
// Parameter MEM_LATENCY (1..7): cycles from mem_read to valid mem_rdata.
// Optional macro LOAD_ALIGN_CHECK_EN: odd effective addresses are rejected
// at acceptance like an illegal address mode.
module memory_load_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  addr_sel,
  input  logic [1:0]  dst_sel,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  input  logic [15:0] mary_data,
  input  logic [15:0] shelley_data,
  input  logic [7:0]  imm,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic [15:0] mem_rdata,
  output logic [15:0] wb_data,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        ra_write,
  output logic        comp_write,
  input  logic        wb_ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW    = 16;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dst_q, dst_d;
  logic [AW-1:0]    mem_addr_d;
  logic             mem_read_d;
  logic [AW-1:0]    wb_data_d;
  logic [3:0]       stb_q, stb_d;
  logic             err_d;

  logic [AW-1:0]    imm_sext;
  logic [AW-1:0]    eff_addr;
  logic             mode_legal;
  logic             addr_ok;

  // Effective address; modulo-2^16 arithmetic, shift applied after sign extension.
  assign imm_sext = {{8{imm[7]}}, imm};

  always_comb begin
    eff_addr   = '0;
    mode_legal = 1'b1;
    case (addr_sel)
      3'b000:  eff_addr = pc;
      3'b001:  eff_addr = imm_sext;
      3'b010:  eff_addr = mary_data;
      3'b011:  eff_addr = shelley_data;
      3'b100:  eff_addr = sp + AW'(2);
      3'b101:  eff_addr = sp + (imm_sext << 2);
      default: mode_legal = 1'b0;
    endcase
  end

`ifdef LOAD_ALIGN_CHECK_EN
  assign addr_ok = mode_legal & ~eff_addr[0];
`else
  assign addr_ok = mode_legal;
`endif

  // State register and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dst_q    <= '0;
      mem_addr <= '0;
      mem_read <= 1'b0;
      wb_data  <= '0;
      stb_q    <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
      mem_addr <= mem_addr_d;
      mem_read <= mem_read_d;
      wb_data  <= wb_data_d;
      stb_q    <= stb_d;
      err      <= err_d;
    end
  end

  // Next-state and next-output logic; mem_read and err are single-cycle pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dst_d      = dst_q;
    mem_addr_d = mem_addr;
    mem_read_d = 1'b0;
    wb_data_d  = wb_data;
    stb_d      = stb_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dst_d = dst_sel;
          if (addr_ok) begin
            mem_addr_d = eff_addr;
            mem_read_d = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_ISSUE: begin
        // A zero load makes WAIT capture on its first edge (latency 1).
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          wb_data_d = mem_rdata;
          stb_d     = 4'b0001 << dst_q;
          state_d   = S_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB: begin
        if (wb_ready) begin
          stb_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mary_write    = stb_q[0];
  assign shelley_write = stb_q[1];
  assign ra_write      = stb_q[2];
  assign comp_write    = stb_q[3];

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule
